// File: rtl/uproc_ctrl.sv
// Three-cycle (FETCH/DECODE/EXEC) control sequencer for the ALU/accumulator/CY datapath.
// Fetches 16-bit instructions from program memory and emits datapath, register-file and PC control.
module uproc_ctrl #(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned RADDR_W = 4
) (
    input  logic               clk,
    input  logic               nReset,
    input  logic               run,
    input  logic [15:0]        instr,
    input  logic               CY,
    input  logic               A_zero,
    output logic [PC_W-1:0]    pc_addr,
    output logic [2:0]         ALUCode,
    output logic               A_CE,
    output logic               CY_CE,
    output logic               R_sel,
    output logic [7:0]         imm,
    output logic [RADDR_W-1:0] reg_rd_addr,
    output logic               reg_we,
    output logic [RADDR_W-1:0] reg_wr_addr,
    output logic               halted,
    output logic               illegal
);

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_LD  = 3'd6;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ALU = 4'h1;
    localparam logic [3:0] OP_ST  = 4'h2;
    localparam logic [3:0] OP_JMP = 4'h3;
    localparam logic [3:0] OP_JC  = 4'h4;
    localparam logic [3:0] OP_JZ  = 4'h5;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {StFetch, StDecode, StExec, StHalt} state_e;

    state_e            r_state;
    logic [PC_W-1:0]   r_pc;
    logic [15:0]       r_ir;
    logic [2:0]        r_alu_code;
    logic              r_a_ce;
    logic              r_cy_ce;
    logic              r_reg_we;
    logic              r_halted;
    logic              r_illegal;

    logic [3:0]        w_op;
    logic              w_legal;
    logic              w_carry_op;
    logic              w_take_jump;

    assign w_op       = r_ir[15:12];
    assign w_legal    = (w_op <= OP_JZ) || (w_op == OP_HLT);
    assign w_carry_op = (r_ir[10:8] == ALU_ADD) || (r_ir[10:8] == ALU_SUB);
    assign w_take_jump = (w_op == OP_JMP) || ((w_op == OP_JC) && CY) ||
                         ((w_op == OP_JZ) && A_zero);

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state    <= StFetch;
            r_pc       <= '0;
            r_ir       <= 16'h0000;
            r_alu_code <= ALU_LD;
            r_a_ce     <= 1'b0;
            r_cy_ce    <= 1'b0;
            r_reg_we   <= 1'b0;
            r_halted   <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            // Enables and illegal are single-cycle pulses; they only rise on DECODE->EXEC.
            r_a_ce    <= 1'b0;
            r_cy_ce   <= 1'b0;
            r_reg_we  <= 1'b0;
            r_illegal <= 1'b0;
            unique case (r_state)
                StFetch: begin
                    if (run) begin
                        r_ir       <= instr;
                        r_alu_code <= instr[10:8];
                        r_pc       <= r_pc + PC_W'(1);
                        r_state    <= StDecode;
                    end
                end
                StDecode: begin
                    r_a_ce    <= (w_op == OP_ALU);
                    r_cy_ce   <= (w_op == OP_ALU) && w_carry_op;
                    r_reg_we  <= (w_op == OP_ST);
                    r_illegal <= !w_legal;
                    r_state   <= StExec;
                end
                StExec: begin
                    if (w_take_jump) begin
                        r_pc <= PC_W'(r_ir[7:0]);
                    end
                    if (w_op == OP_HLT) begin
                        r_halted <= 1'b1;
                        r_state  <= StHalt;
                    end else begin
                        r_state  <= StFetch;
                    end
                end
                StHalt: begin
                    r_state <= StHalt;
                end
                default: begin
                    r_state <= StFetch;
                end
            endcase
        end
    end

    // Operand fields come straight from IR, which only changes in FETCH.
    assign pc_addr     = r_pc;
    assign ALUCode     = r_alu_code;
    assign R_sel       = r_ir[11];
    assign imm         = r_ir[7:0];
    assign reg_rd_addr = r_ir[RADDR_W-1:0];
    assign reg_wr_addr = r_ir[RADDR_W-1:0];
    assign A_CE        = r_a_ce;
    assign CY_CE       = r_cy_ce;
    assign reg_we      = r_reg_we;
    assign halted      = r_halted;
    assign illegal     = r_illegal;

endmodule

// File: tb/tb_uproc_ctrl.sv
// Directed self-checking bench for uproc_ctrl with a small accumulator/CY/register-file model
// and a program memory array driving instr.
module tb_uproc_ctrl;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_NOT = 3'd5;
    localparam logic [2:0] ALU_LD  = 3'd6;

    logic        clk = 1'b0;
    logic        nReset;
    logic        run;
    logic [15:0] instr;
    logic        CY;
    logic        A_zero;
    logic [7:0]  pc_addr;
    logic [2:0]  ALUCode;
    logic        A_CE;
    logic        CY_CE;
    logic        R_sel;
    logic [7:0]  imm;
    logic [3:0]  reg_rd_addr;
    logic        reg_we;
    logic [3:0]  reg_wr_addr;
    logic        halted;
    logic        illegal;

    logic [15:0] mem [0:255];
    logic [7:0]  m_a;
    logic        m_cy;
    logic [7:0]  m_regs [0:15];
    logic [7:0]  w_r;
    logic [8:0]  w_alu;

    int n_pass  = 0;
    int n_total = 0;

    uproc_ctrl #(.PC_W(8), .RADDR_W(4)) dut (
        .clk        (clk),
        .nReset     (nReset),
        .run        (run),
        .instr      (instr),
        .CY         (CY),
        .A_zero     (A_zero),
        .pc_addr    (pc_addr),
        .ALUCode    (ALUCode),
        .A_CE       (A_CE),
        .CY_CE      (CY_CE),
        .R_sel      (R_sel),
        .imm        (imm),
        .reg_rd_addr(reg_rd_addr),
        .reg_we     (reg_we),
        .reg_wr_addr(reg_wr_addr),
        .halted     (halted),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    assign instr  = mem[pc_addr];
    assign CY     = m_cy;
    assign A_zero = (m_a == 8'h00);
    assign w_r    = R_sel ? imm : m_regs[reg_rd_addr];

    function automatic logic [8:0] alu_f(input logic [2:0] code, input logic [7:0] a,
                                         input logic [7:0] r, input logic cy);
        case (code)
            ALU_ADD: return {1'b0, a} + {1'b0, r};
            ALU_SUB: return {1'b0, a} - {1'b0, r};
            ALU_AND: return {cy, a & r};
            ALU_OR:  return {cy, a | r};
            ALU_XOR: return {cy, a ^ r};
            ALU_NOT: return {cy, ~a};
            ALU_LD:  return {cy, r};
            default: return {cy, a};
        endcase
    endfunction

    assign w_alu = alu_f(ALUCode, m_a, w_r, m_cy);

    always @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            m_a  <= 8'h00;
            m_cy <= 1'b0;
            for (int i = 0; i < 16; i++) m_regs[i] <= 8'h00;
        end else begin
            if (A_CE)   m_a  <= w_alu[7:0];
            if (CY_CE)  m_cy <= w_alu[8];
            if (reg_we) m_regs[reg_wr_addr] <= m_a;
        end
    end

    task automatic hold_reset();
        nReset = 1'b0;
        run    = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        #3;
    endtask

    task automatic release_reset(input logic run_val);
        @(negedge clk);
        nReset = 1'b1;
        run    = run_val;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        hold_reset();
        #7;
        n_total++;
        if (pc_addr !== 8'h00) $display("FAIL reset_pc: got %0h expected 0", pc_addr);
        else n_pass++;
        n_total++;
        if (ALUCode !== ALU_LD) $display("FAIL reset_alucode: got %0d expected %0d", ALUCode, ALU_LD);
        else n_pass++;
        n_total++;
        if ({A_CE, CY_CE, reg_we, R_sel, halted, illegal} !== 6'b0)
            $display("FAIL reset_flags: got %b expected 000000",
                     {A_CE, CY_CE, reg_we, R_sel, halted, illegal});
        else n_pass++;
    endtask

    task automatic test_alu_imm();
        hold_reset();
        mem[0] = 16'h1804;
        release_reset(1'b1);
        tick(1);
        n_total++;
        if ({pc_addr, ALUCode, R_sel, imm, A_CE} !== {8'h01, ALU_ADD, 1'b1, 8'h04, 1'b0})
            $display("FAIL addi_decode: got pc=%0h alu=%0d rsel=%b imm=%0h ace=%b expected pc=1 alu=0 rsel=1 imm=4 ace=0",
                     pc_addr, ALUCode, R_sel, imm, A_CE);
        else n_pass++;
        tick(1);
        n_total++;
        if ({A_CE, CY_CE} !== 2'b11) $display("FAIL addi_exec_en: got %b expected 11", {A_CE, CY_CE});
        else n_pass++;
        tick(1);
        n_total++;
        if ({A_CE, m_a} !== {1'b0, 8'd4}) $display("FAIL addi_result: got ace=%b a=%0d expected ace=0 a=4", A_CE, m_a);
        else n_pass++;
    endtask

    task automatic test_add_chain();
        hold_reset();
        mem[0] = 16'h1804; mem[1] = 16'h1804; mem[2] = 16'h1804; mem[3] = 16'hF000;
        release_reset(1'b1);
        tick(9);
        n_total++;
        if (m_a !== 8'd12) $display("FAIL chain_acc: got %0d expected 12", m_a);
        else n_pass++;
        tick(2);
        n_total++;
        if (halted !== 1'b0) $display("FAIL chain_not_halted: got %b expected 0", halted);
        else n_pass++;
        tick(1);
        n_total++;
        if ({halted, pc_addr} !== {1'b1, 8'h04}) $display("FAIL chain_halt: got halted=%b pc=%0h expected 1 4", halted, pc_addr);
        else n_pass++;
        tick(5);
        n_total++;
        if ({halted, pc_addr, A_CE, reg_we} !== {1'b1, 8'h04, 2'b00})
            $display("FAIL chain_halt_hold: got halted=%b pc=%0h ace=%b we=%b expected 1 4 0 0",
                     halted, pc_addr, A_CE, reg_we);
        else n_pass++;
    endtask

    task automatic test_jumps();
        hold_reset();
        mem[0] = 16'h1EFB; mem[1] = 16'h180A; mem[2] = 16'h4020;
        release_reset(1'b1);
        tick(6);
        n_total++;
        if ({m_cy, m_a} !== {1'b1, 8'd5}) $display("FAIL carry_set: got cy=%b a=%0d expected 1 5", m_cy, m_a);
        else n_pass++;
        tick(3);
        n_total++;
        if (pc_addr !== 8'h20) $display("FAIL jc_taken: got %0h expected 20", pc_addr);
        else n_pass++;

        hold_reset();
        mem[0] = 16'h1E01; mem[1] = 16'h180A; mem[2] = 16'h4020;
        release_reset(1'b1);
        tick(9);
        n_total++;
        if (pc_addr !== 8'h03) $display("FAIL jc_not_taken: got %0h expected 3", pc_addr);
        else n_pass++;

        hold_reset();
        mem[0] = 16'h1E00; mem[1] = 16'h5040;
        release_reset(1'b1);
        tick(6);
        n_total++;
        if (pc_addr !== 8'h40) $display("FAIL jz_taken: got %0h expected 40", pc_addr);
        else n_pass++;
    endtask

    task automatic test_cy_hold_and_store();
        hold_reset();
        mem[0] = 16'h1EFB; mem[1] = 16'h180A; mem[2] = 16'h1A0F; mem[3] = 16'h2003;
        release_reset(1'b1);
        tick(8);
        n_total++;
        if ({A_CE, CY_CE} !== 2'b10) $display("FAIL andi_enables: got %b expected 10", {A_CE, CY_CE});
        else n_pass++;
        tick(1);
        n_total++;
        if ({m_cy, m_a} !== {1'b1, 8'd5}) $display("FAIL andi_cy_held: got cy=%b a=%0d expected 1 5", m_cy, m_a);
        else n_pass++;
        tick(1);
        n_total++;
        if (reg_we !== 1'b0) $display("FAIL st_decode_we: got %b expected 0", reg_we);
        else n_pass++;
        tick(1);
        n_total++;
        if ({reg_we, reg_wr_addr, A_CE} !== {1'b1, 4'd3, 1'b0})
            $display("FAIL st_exec: got we=%b addr=%0d ace=%b expected 1 3 0", reg_we, reg_wr_addr, A_CE);
        else n_pass++;
        tick(1);
        n_total++;
        if ({reg_we, m_regs[3]} !== {1'b0, 8'd5}) $display("FAIL st_pulse: got we=%b r3=%0d expected 0 5", reg_we, m_regs[3]);
        else n_pass++;
    endtask

    task automatic test_run_stall_wrap();
        hold_reset();
        mem[0] = 16'h30FF;
        release_reset(1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            n_total++;
            if ({pc_addr, A_CE, CY_CE, reg_we} !== {8'h00, 3'b000})
                $display("FAIL stall_%0d: got pc=%0h en=%b expected pc=0 en=000", i, pc_addr, {A_CE, CY_CE, reg_we});
            else n_pass++;
        end
        run = 1'b1;
        tick(3);
        n_total++;
        if (pc_addr !== 8'hFF) $display("FAIL jmp_ff: got %0h expected ff", pc_addr);
        else n_pass++;
        tick(1);
        n_total++;
        if (pc_addr !== 8'h00) $display("FAIL pc_wrap: got %0h expected 0", pc_addr);
        else n_pass++;
    endtask

    task automatic test_illegal_and_reset();
        hold_reset();
        mem[0] = 16'h7000;
        release_reset(1'b1);
        tick(1);
        n_total++;
        if (illegal !== 1'b0) $display("FAIL illegal_decode: got %b expected 0", illegal);
        else n_pass++;
        tick(1);
        n_total++;
        if ({illegal, A_CE, CY_CE, reg_we} !== 4'b1000)
            $display("FAIL illegal_exec: got %b expected 1000", {illegal, A_CE, CY_CE, reg_we});
        else n_pass++;
        tick(1);
        n_total++;
        if ({illegal, pc_addr} !== {1'b0, 8'h01}) $display("FAIL illegal_after: got ill=%b pc=%0h expected 0 1", illegal, pc_addr);
        else n_pass++;

        hold_reset();
        mem[0] = 16'h1804;
        release_reset(1'b1);
        tick(2);
        n_total++;
        if (A_CE !== 1'b1) $display("FAIL midexec_ace: got %b expected 1", A_CE);
        else n_pass++;
        #2;
        nReset = 1'b0;
        #1;
        n_total++;
        if ({A_CE, CY_CE, pc_addr} !== {2'b00, 8'h00})
            $display("FAIL midexec_abort: got ace=%b cye=%b pc=%0h expected 0 0 0", A_CE, CY_CE, pc_addr);
        else n_pass++;
        release_reset(1'b1);
        tick(1);
        n_total++;
        if ({pc_addr, ALUCode, m_a} !== {8'h01, ALU_ADD, 8'h00})
            $display("FAIL refetch: got pc=%0h alu=%0d a=%0d expected 1 0 0", pc_addr, ALUCode, m_a);
        else n_pass++;
        tick(2);
        n_total++;
        if (m_a !== 8'd4) $display("FAIL reexec: got %0d expected 4", m_a);
        else n_pass++;
    endtask

    initial begin
        nReset = 1'b0;
        run    = 1'b0;
        test_reset();
        test_alu_imm();
        test_add_chain();
        test_jumps();
        test_cy_hold_and_store();
        test_run_stall_wrap();
        test_illegal_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
